// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, long-latency
// results queue in a FIFO and drain into free slots. Optional macro: WB_HAZARD_EN.
module wb_port_arbiter #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MAX_WAIT = 8,
    parameter int unsigned XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            reg_write_WB,
    input  logic [4:0]      rd_WB,
    input  logic [XLEN-1:0] write_data_WB,
    input  logic            ll_valid,
    output logic            ll_ready,
    input  logic [4:0]      ll_rd,
    input  logic [XLEN-1:0] ll_data,
`ifdef WB_HAZARD_EN
    input  logic [4:0]      rs1_D,
    input  logic [4:0]      rs2_D,
    output logic            ll_hazard_D,
`endif
    output logic            stall_WB,
    output logic            rf_we,
    output logic [4:0]      rf_rd,
    output logic [XLEN-1:0] rf_wdata,
    output logic            ll_pending
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam int unsigned AW = $clog2(MAX_WAIT + 1);

    logic [4:0]      fifo_rd_q   [DEPTH];
    logic [4:0]      fifo_rd_d   [DEPTH];
    logic [XLEN-1:0] fifo_data_q [DEPTH];
    logic [XLEN-1:0] fifo_data_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   age_q, age_d;
    logic            rf_we_q, rf_we_d;
    logic [4:0]      rf_rd_q, rf_rd_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;

    logic wb_req;
    logic push;
    logic pop;
    logic force_drain;

    always_comb begin
        wb_req      = reg_write_WB && (rd_WB != '0);
        ll_ready    = (count_q < CW'(DEPTH));
        ll_pending  = (count_q != '0);
        push        = ll_valid && ll_ready && (ll_rd != '0);
        force_drain = (age_q == AW'(MAX_WAIT)) && ll_pending && wb_req;
        pop         = force_drain || (!wb_req && ll_pending);
        stall_WB    = force_drain;
        rf_we       = rf_we_q;
        rf_rd       = rf_rd_q;
        rf_wdata    = rf_wdata_q;
    end

    always_comb begin
        fifo_rd_d   = fifo_rd_q;
        fifo_data_d = fifo_data_q;
        if (push) begin
            fifo_rd_d[wr_ptr_q]   = ll_rd;
            fifo_data_d[wr_ptr_q] = ll_data;
        end
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);

        // Age measures how long the current head has been passed over.
        if (pop || !ll_pending)
            age_d = '0;
        else if (age_q != AW'(MAX_WAIT))
            age_d = age_q + AW'(1);
        else
            age_d = age_q;

        rf_we_d    = pop || wb_req;
        rf_rd_d    = rf_rd_q;
        rf_wdata_d = rf_wdata_q;
        if (pop) begin
            rf_rd_d    = fifo_rd_q[rd_ptr_q];
            rf_wdata_d = fifo_data_q[rd_ptr_q];
        end else if (wb_req) begin
            rf_rd_d    = rd_WB;
            rf_wdata_d = write_data_WB;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fifo_rd_q[i]   <= '0;
                fifo_data_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            age_q      <= '0;
            rf_we_q    <= 1'b0;
            rf_rd_q    <= '0;
            rf_wdata_q <= '0;
        end else begin
            fifo_rd_q   <= fifo_rd_d;
            fifo_data_q <= fifo_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            age_q       <= age_d;
            rf_we_q     <= rf_we_d;
            rf_rd_q     <= rf_rd_d;
            rf_wdata_q  <= rf_wdata_d;
        end
    end

`ifdef WB_HAZARD_EN
    logic [PW-1:0] hz_idx;

    // Match decode sources against live FIFO slots and the transfer entering now.
    always_comb begin
        ll_hazard_D = 1'b0;
        hz_idx      = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            hz_idx = rd_ptr_q + PW'(i);
            if (CW'(i) < count_q) begin
                if ((rs1_D != '0) && (rs1_D == fifo_rd_q[hz_idx]))
                    ll_hazard_D = 1'b1;
                if ((rs2_D != '0) && (rs2_D == fifo_rd_q[hz_idx]))
                    ll_hazard_D = 1'b1;
            end
        end
        if (push) begin
            if ((rs1_D != '0) && (rs1_D == ll_rd))
                ll_hazard_D = 1'b1;
            if ((rs2_D != '0) && (rs2_D == ll_rd))
                ll_hazard_D = 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed table, multi-cycle corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_wb_port_arbiter;

    localparam int unsigned DEPTH    = 4;
    localparam int unsigned MAX_WAIT = 8;
    localparam int unsigned XLEN     = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            reg_write_WB = 1'b0;
    logic [4:0]      rd_WB = '0;
    logic [XLEN-1:0] write_data_WB = '0;
    logic            ll_valid = 1'b0;
    logic            ll_ready;
    logic [4:0]      ll_rd = '0;
    logic [XLEN-1:0] ll_data = '0;
    logic            stall_WB;
    logic            rf_we;
    logic [4:0]      rf_rd;
    logic [XLEN-1:0] rf_wdata;
    logic            ll_pending;
`ifdef WB_HAZARD_EN
    logic [4:0]      rs1_D = '0;
    logic [4:0]      rs2_D = '0;
    logic            ll_hazard_D;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wb_port_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT), .XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .reg_write_WB(reg_write_WB), .rd_WB(rd_WB), .write_data_WB(write_data_WB),
        .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_rd(ll_rd), .ll_data(ll_data),
`ifdef WB_HAZARD_EN
        .rs1_D(rs1_D), .rs2_D(rs2_D), .ll_hazard_D(ll_hazard_D),
`endif
        .stall_WB(stall_WB), .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
        .ll_pending(ll_pending)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock of stimulus with expected comb outputs (this cycle) and rf outputs (after the edge).
    task automatic cyc(input string name,
                       input logic wr, input logic [4:0] rd, input logic [31:0] d,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                       input logic es, input logic er, input logic ep,
                       input logic ewe, input logic [4:0] erd, input logic [31:0] ewd);
        @(negedge clk);
        reg_write_WB = wr; rd_WB = rd; write_data_WB = d;
        ll_valid = lv; ll_rd = lrd; ll_data = ld;
        #1;
        check({name, ".stall"}, 64'(stall_WB), 64'(es));
        check({name, ".ready"}, 64'(ll_ready), 64'(er));
        check({name, ".pend"},  64'(ll_pending), 64'(ep));
        @(posedge clk);
        #1;
        check({name, ".we"},    64'(rf_we), 64'(ewe));
        check({name, ".rd"},    64'(rf_rd), 64'(erd));
        check({name, ".wdata"}, 64'(rf_wdata), 64'(ewd));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        reg_write_WB = 1'b0; rd_WB = '0; write_data_WB = '0;
        ll_valid = 1'b0; ll_rd = '0; ll_data = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic wr; logic [4:0] rd; logic [31:0] d;
        logic lv; logic [4:0] lrd; logic [31:0] ld;
        logic es; logic er; logic ep;
        logic ewe; logic [4:0] erd; logic [31:0] ewd;
    } vec_t;

    typedef struct { logic [4:0] rd; logic [31:0] d; } ent_t;

    vec_t tbl [7];
    ent_t q [$];
    int   m_age;
    logic m_we;
    logic [4:0]  m_rd;
    logic [31:0] m_wd;
    logic m_req, m_force, m_pop, hold;
    ent_t e;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1, 5, 32'hDEADBEEF, 0, 0, 0,        0, 1, 0, 1, 5, 32'hDEADBEEF};
        tbl[1] = '{1, 0, 32'h00000001, 0, 0, 0,        0, 1, 0, 0, 5, 32'hDEADBEEF};
        tbl[2] = '{0, 0, 0,            1, 7, 32'h1234, 0, 1, 0, 0, 5, 32'hDEADBEEF};
        tbl[3] = '{0, 0, 0,            0, 0, 0,        0, 1, 1, 1, 7, 32'h1234};
        tbl[4] = '{0, 0, 0,            0, 0, 0,        0, 1, 0, 0, 7, 32'h1234};
        tbl[5] = '{0, 0, 0,            1, 0, 32'h99,   0, 1, 0, 0, 7, 32'h1234};
        tbl[6] = '{0, 0, 0,            0, 0, 0,        0, 1, 0, 0, 7, 32'h1234};

        // Reset values
        #1;
        check("rst.we", 64'(rf_we), 64'd0);
        check("rst.rd", 64'(rf_rd), 64'd0);
        check("rst.wdata", 64'(rf_wdata), 64'd0);
        check("rst.pend", 64'(ll_pending), 64'd0);
        check("rst.ready", 64'(ll_ready), 64'd1);
        check("rst.stall", 64'(stall_WB), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++)
            cyc($sformatf("tbl%0d", i), tbl[i].wr, tbl[i].rd, tbl[i].d, tbl[i].lv, tbl[i].lrd,
                tbl[i].ld, tbl[i].es, tbl[i].er, tbl[i].ep, tbl[i].ewe, tbl[i].erd, tbl[i].ewd);

        // Fill the FIFO behind continuous WB traffic, then drain in order
        do_reset();
        cyc("full_p0", 1, 3, 32'h33, 1, 11, 32'hA0, 0, 1, 0, 1, 3, 32'h33);
        cyc("full_p1", 1, 3, 32'h33, 1, 12, 32'hA1, 0, 1, 1, 1, 3, 32'h33);
        cyc("full_p2", 1, 3, 32'h33, 1, 13, 32'hA2, 0, 1, 1, 1, 3, 32'h33);
        cyc("full_p3", 1, 3, 32'h33, 1, 14, 32'hA3, 0, 1, 1, 1, 3, 32'h33);
        cyc("full_w4", 1, 3, 32'h33, 1, 15, 32'hA4, 0, 0, 1, 1, 3, 32'h33);
        cyc("full_d0", 0, 0, 0,      1, 15, 32'hA4, 0, 0, 1, 1, 11, 32'hA0);
        cyc("full_d1", 0, 0, 0,      1, 15, 32'hA4, 0, 1, 1, 1, 12, 32'hA1);
        cyc("full_d2", 0, 0, 0,      0, 0, 0,       0, 1, 1, 1, 13, 32'hA2);
        cyc("full_d3", 0, 0, 0,      0, 0, 0,       0, 1, 1, 1, 14, 32'hA3);
        cyc("full_d4", 0, 0, 0,      0, 0, 0,       0, 1, 1, 1, 15, 32'hA4);
        cyc("full_e",  0, 0, 0,      0, 0, 0,       0, 1, 0, 0, 15, 32'hA4);

        // Starvation guard: head rd=9 forced out on the cycle age hits MAX_WAIT
        do_reset();
        cyc("starv_c0", 1, 4, 32'h40, 1, 9, 32'h99, 0, 1, 0, 1, 4, 32'h40);
        for (int k = 1; k <= 8; k++)
            cyc($sformatf("starv_c%0d", k), 1, 4, 32'h40 + k, 0, 0, 0, 0, 1, 1, 1, 4, 32'h40 + k);
        cyc("starv_force", 1, 4, 32'h49, 0, 0, 0, 1, 1, 1, 1, 9, 32'h99);
        cyc("starv_held",  1, 4, 32'h49, 0, 0, 0, 0, 1, 0, 1, 4, 32'h49);

        // Reset with three queued entries discards them
        do_reset();
        cyc("mrst_p0", 1, 2, 32'h22, 1, 20, 32'hB0, 0, 1, 0, 1, 2, 32'h22);
        cyc("mrst_p1", 1, 2, 32'h22, 1, 21, 32'hB1, 0, 1, 1, 1, 2, 32'h22);
        cyc("mrst_p2", 1, 2, 32'h22, 1, 22, 32'hB2, 0, 1, 1, 1, 2, 32'h22);
        @(negedge clk);
        rst_n = 1'b0;
        reg_write_WB = 1'b0; ll_valid = 1'b0;
        #1;
        check("mrst.we", 64'(rf_we), 64'd0);
        check("mrst.pend", 64'(ll_pending), 64'd0);
        check("mrst.ready", 64'(ll_ready), 64'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++)
            cyc($sformatf("mrst_idle%0d", k), 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);

        // Randomized traffic against the queue model
        do_reset();
        q.delete();
        m_age = 0; m_we = 1'b0; m_rd = '0; m_wd = '0; hold = 1'b0;
        for (int i = 0; i < 640; i++) begin
            @(negedge clk);
            if (!hold) begin
                reg_write_WB  = ($urandom_range(99) < (((i / 64) % 2) != 0 ? 95 : 30));
                rd_WB         = 5'($urandom_range(31));
                write_data_WB = $urandom;
            end
            ll_valid = ($urandom_range(99) < 40);
            ll_rd    = 5'($urandom_range(31));
            ll_data  = $urandom;
            #1;
            m_req   = reg_write_WB && (rd_WB != 0);
            m_force = (m_age == MAX_WAIT) && (q.size() > 0) && m_req;
            m_pop   = m_force || (!m_req && q.size() > 0);
            check("rnd.stall", 64'(stall_WB), 64'(m_force));
            check("rnd.ready", 64'(ll_ready), 64'(q.size() < DEPTH));
            check("rnd.pend",  64'(ll_pending), 64'(q.size() != 0));
            hold = m_force;
            m_we = m_pop || m_req;
            if (m_pop) begin
                e = q.pop_front();
                m_rd = e.rd; m_wd = e.d;
            end else if (m_req) begin
                m_rd = rd_WB; m_wd = write_data_WB;
            end
            if (m_pop || (q.size() == 0 && !m_pop)) m_age = 0;
            else if (m_age < MAX_WAIT) m_age++;
            if (ll_valid && (q.size() + (m_pop ? 1 : 0) < DEPTH) && ll_rd != 0)
                q.push_back('{ll_rd, ll_data});
            @(posedge clk);
            #1;
            check("rnd.we",    64'(rf_we), 64'(m_we));
            check("rnd.rd",    64'(rf_rd), 64'(m_rd));
            check("rnd.wdata", 64'(rf_wdata), 64'(m_wd));
        end

`ifdef WB_HAZARD_EN
        do_reset();
        rs1_D = 5'd0; rs2_D = 5'd12;
        @(negedge clk);
        reg_write_WB = 1'b1; rd_WB = 5'd3; ll_valid = 1'b1; ll_rd = 5'd12; ll_data = 32'hC0;
        #1; check("hz.accept", 64'(ll_hazard_D), 64'd1);
        @(negedge clk);
        ll_valid = 1'b0;
        #1; check("hz.queued", 64'(ll_hazard_D), 64'd1);
        @(negedge clk);
        reg_write_WB = 1'b0;
        #1; check("hz.popping", 64'(ll_hazard_D), 64'd1);
        @(negedge clk);
        #1; check("hz.cleared", 64'(ll_hazard_D), 64'd0);
        check("hz.write", 64'(rf_rd), 64'd12);
        rs2_D = 5'd0;
        @(negedge clk);
        reg_write_WB = 1'b1; ll_valid = 1'b1; ll_rd = 5'd12;
        #1; check("hz.rs_zero", 64'(ll_hazard_D), 64'd0);
        @(negedge clk);
        reg_write_WB = 1'b0; ll_valid = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Owns the single register-file write port and shares it between two requesters: the in-order pipeline writeback stage (WB) and a long-latency result source (LL), such as a multi-cycle divider or an out-of-band load return.
- WB has priority.
- LL results are queued in a small FIFO and drained into free WB slots.
- A starvation guard briefly stalls the pipeline so queued LL results always retire.

Parameters:
- DEPTH, 4, LL result FIFO entries (power of two, ≥2)
- MAX_WAIT, 8, cycles the FIFO head may wait before a forced drain stall
- XLEN, 32, data width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- reg_write_WB  in  1  pipeline WB wants to write
- rd_WB  in  5  pipeline destination register
- write_data_WB  in  XLEN  pipeline result (already muxed ALU/mem/PC+4)
- ll_valid  in  1  LL result offered
- ll_ready  out  1  FIFO can accept LL result
- ll_rd  in  5  LL destination register
- ll_data  in  XLEN  LL result
- stall_WB  out  1  freeze pipeline this cycle; WB inputs must be held stable
- rf_we  out  1  register-file write enable (registered)
- rf_rd  out  5  register-file write address (registered)
- rf_wdata  out  XLEN  register-file write data (registered)
- ll_pending  out  1  FIFO non-empty

Behaviour:
- Reset (async, rst_n=0):
  - rf_we=0, rf_rd=0, rf_wdata=0.
  - FIFO empty: count=0, read and write pointers=0.
  - Age counter=0, stall_WB=0.
  - ll_ready=1 once out of reset; ll_pending=0.
  - Reset mid-operation discards all queued entries.
- Slot definitions:
  - wb_req = reg_write_WB && rd_WB!=0.
  - A writeback with rd_WB=0 is a free slot and never produces rf_we.
- Enqueue:
  - ll_ready = (count<DEPTH), combinational from state only. No same-cycle pop-to-push bypass, so a full FIFO stays not-ready even while popping.
  - Handshake on ll_valid && ll_ready.
  - If ll_rd=0, the transfer completes but the entry is discarded (not stored).
- Age counter:
  - Counts cycles the head entry has been valid and not popped; saturates at MAX_WAIT.
  - Clears to 0 on every pop and whenever the FIFO is empty.
- Selection, evaluated each cycle:
  - force = (age==MAX_WAIT) && count>0 && wb_req.
  - stall_WB = force (combinational).
  - If force: pop the head; the WB write is not performed this cycle and will be repeated next cycle because the pipeline holds.
  - Else if wb_req: write WB; FIFO untouched.
  - Else if count>0: pop the head.
  - Else: no write.
- Output register: the winner's {1, rd, data} is registered into rf_we/rf_rd/rf_wdata at the next edge, giving 1-cycle latency from selection to write. With no winner, rf_we=0 and rf_rd/rf_wdata hold their previous values.
- Simultaneous push and pop: count unchanged. Pointers wrap modulo DEPTH.
- Ordering:
  - LL results retire in FIFO order.
  - The starvation guard bounds LL retirement to at most MAX_WAIT+1 cycles per head entry.
  - WB is delayed at most one cycle per forced drain.
- ll_pending = (count!=0).

Optional Feature:
- Macro: WB_HAZARD_EN.
- When defined, adds ports:
  - rs1_D in 5
  - rs2_D in 5
  - ll_hazard_D out 1
- ll_hazard_D is asserted combinationally when rs1_D or rs2_D is nonzero and equals the rd of any valid FIFO entry, or of an LL transfer being accepted this cycle. Decode uses this to stall until the queued value has been written.
- When undefined, these ports and the match logic are absent; correctness of LL dependencies is then the issuing unit's responsibility.

Test Plan:
- Reset: assert rst_n=0 mid-stream with 3 queued entries -> rf_we=0, ll_pending=0, ll_ready=1 immediately; after release, no stale writes appear.
- WB only: reg_write_WB=1, rd_WB=5, data=0xDEADBEEF -> next cycle rf_we=1, rf_rd=5, rf_wdata=0xDEADBEEF. Same stimulus with rd_WB=0 -> rf_we=0.
- Drain in free slot: push LL (rd=7, 0x1234) while reg_write_WB=0 -> pushed in cycle 0, popped in cycle 1, rf_we=1/rd=7/0x1234 visible after the cycle-1 edge.
- Full FIFO: hold wb_req=1 continuously and push 4 LL results with MAX_WAIT large -> ll_ready=0 after the 4th push; a 5th ll_valid waits. When wb_req drops, entries retire in push order, with ll_ready=1 after the first pop.
- Starvation: MAX_WAIT=8, one queued entry (rd=9), wb_req=1 every cycle -> stall_WB=1 exactly on the cycle age reaches 8, the rd=9 write follows, and the held WB write appears on the next cycle.
- WB_HAZARD_EN: queue rd=12 and drive rs2_D=12 -> ll_hazard_D=1, clearing the cycle after the rd=12 entry pops. rs1_D=0 never flags.
